// File: rtl/run_ctrl_pkg.sv
// Shared types and constants for the run_ctrl host sequencer.
package run_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        CORE_RST = 3'd2,
        RUN      = 3'd3,
        UNLOAD   = 3'd4
    } state_e;

    localparam int CORE_RST_CYCLES = 2;

endpackage

// File: rtl/run_ctrl_up_cnt.sv
// Up counter with synchronous clear (priority), enable and saturation at MAX.
module up_cnt #(
    parameter int           W   = 8,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt_q
);

    logic [W-1:0] cnt_d;

    // Next count: clear wins over enable, hold once MAX is reached.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != MAX)) begin
            cnt_d = cnt_q + W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/run_ctrl.sv
// Host sequencer: preload data memory, run the core under a timeout, stream results out.
// Define RUN_CTRL_CYCLE_CNT_EN to export the run-cycle counter on cycle_cnt.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int               AW          = 8,
    parameter int               LOAD_BASE   = 0,
    parameter int               LOAD_LEN    = 32,
    parameter int               UNLOAD_BASE = 64,
    parameter int               UNLOAD_LEN  = 32,
    parameter int               TMO_W       = 16,
    parameter logic [TMO_W-1:0] TMO_MAX     = TMO_W'(16'hFFFF)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    output logic             finished,
    output logic             timed_out,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [7:0]       out_data,
    input  logic             out_ready,
    output logic             core_reset,
    output logic             core_req,
    input  logic             core_done,
    output logic             mem_sel,
    output logic             mem_wr_en,
    output logic [AW-1:0]    mem_addr,
    output logic [7:0]       mem_wr_data,
    input  logic [7:0]       mem_rd_data,
    output logic [TMO_W-1:0] cycle_cnt
);

    localparam int               IDX_W       = 16;
    localparam logic [IDX_W-1:0] LOAD_LAST   = IDX_W'(LOAD_LEN - 1);
    localparam logic [IDX_W-1:0] UNLOAD_LAST = IDX_W'(UNLOAD_LEN - 1);
    localparam logic [IDX_W-1:0] CRST_LAST   = IDX_W'(CORE_RST_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST    = TMO_MAX - TMO_W'(1);

    state_e           state_q, state_d;
    logic             fin_q, fin_d;
    logic             tmo_q, tmo_d;
    logic             idx_clr, idx_en;
    logic             run_clr, run_en;
    logic [IDX_W-1:0] idx_q;
    logic [TMO_W-1:0] run_q;

    // idx serves the load/unload address offset and the core-reset hold count.
    up_cnt #(.W(IDX_W), .MAX('1)) u_idx (
        .clk   (clk),
        .reset (reset),
        .clr   (idx_clr),
        .en    (idx_en),
        .cnt_q (idx_q)
    );

    up_cnt #(.W(TMO_W), .MAX(TMO_MAX)) u_run (
        .clk   (clk),
        .reset (reset),
        .clr   (run_clr),
        .en    (run_en),
        .cnt_q (run_q)
    );

`ifdef RUN_CTRL_CYCLE_CNT_EN
    assign cycle_cnt = run_q;
`else
    assign cycle_cnt = '0;
`endif

    assign busy       = (state_q != IDLE);
    assign in_ready   = (state_q == LOAD);
    assign out_valid  = (state_q == UNLOAD);
    assign core_reset = (state_q != RUN);
    assign mem_sel    = (state_q != RUN);
    assign out_data   = mem_rd_data;
    assign finished   = fin_q;
    assign timed_out  = tmo_q;

    // Next-state, counter control and memory-port decode.
    always_comb begin
        state_d     = state_q;
        fin_d       = fin_q;
        tmo_d       = tmo_q;
        idx_clr     = 1'b0;
        idx_en      = 1'b0;
        run_clr     = 1'b0;
        run_en      = 1'b0;
        core_req    = 1'b0;
        mem_wr_en   = 1'b0;
        mem_addr    = '0;
        mem_wr_data = 8'h00;
        case (state_q)
            IDLE: begin
                if (start) begin
                    fin_d   = 1'b0;
                    tmo_d   = 1'b0;
                    idx_clr = 1'b1;
                    run_clr = 1'b1;
                    state_d = (LOAD_LEN == 0) ? CORE_RST : LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                mem_addr    = AW'(LOAD_BASE) + AW'(idx_q);
                mem_wr_data = in_data;
                if (in_valid) begin
                    mem_wr_en = 1'b1;
                    idx_en    = 1'b1;
                    if (idx_q == LOAD_LAST) begin
                        idx_clr = 1'b1;
                        state_d = CORE_RST;
                    end else begin
                        state_d = LOAD;
                    end
                end else begin
                    state_d = LOAD;
                end
            end
            CORE_RST: begin
                idx_en = 1'b1;
                if (idx_q == CRST_LAST) begin
                    idx_clr = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = CORE_RST;
                end
            end
            RUN: begin
                // run_q is cleared on start, so zero marks the request cycle.
                run_en   = 1'b1;
                core_req = (run_q == '0);
                if (core_done && !core_req) begin
                    if (UNLOAD_LEN == 0) begin
                        fin_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = UNLOAD;
                    end
                end else if (run_q == TMO_LAST) begin
                    tmo_d   = 1'b1;
                    fin_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = RUN;
                end
            end
            UNLOAD: begin
                mem_addr = AW'(UNLOAD_BASE) + AW'(idx_q);
                if (out_ready) begin
                    idx_en = 1'b1;
                    if (idx_q == UNLOAD_LAST) begin
                        idx_clr = 1'b1;
                        fin_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = UNLOAD;
                    end
                end else begin
                    state_d = UNLOAD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and sticky status registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            fin_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fin_q   <= fin_d;
            tmo_q   <= tmo_d;
        end
    end

endmodule

// File: tb/tb_run_ctrl.sv
// Directed self-checking bench for run_ctrl: a 4-byte instance with a copying core model
// and a zero-length instance.
module tb_run_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int          n_cmp = 0;
    int          n_err = 0;

    // Instance A: 4-byte load/unload, timeout after 20 run cycles.
    logic        a_start = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b0;
    logic [7:0]  a_in_data = 8'h00;
    logic        a_busy, a_finished, a_timed_out, a_in_ready, a_out_valid;
    logic [7:0]  a_out_data, a_mem_wr_data, a_mem_rd_data;
    logic        a_core_reset, a_core_req, a_mem_sel, a_mem_wr_en;
    logic        a_core_done = 1'b0;
    logic [7:0]  a_mem_addr;
    logic [15:0] a_cycle_cnt;

    // Instance B: zero-length load and unload.
    logic        b_start = 1'b0, b_core_done = 1'b0;
    logic        b_busy, b_finished, b_timed_out, b_in_ready, b_out_valid;
    logic [7:0]  b_out_data, b_mem_wr_data;
    logic        b_core_reset, b_core_req, b_mem_sel, b_mem_wr_en;
    logic [7:0]  b_mem_addr;
    logic [15:0] b_cycle_cnt;

    logic [7:0]  mem [256];
    int          a_run_k = 0;
    int          a_done_at = 10;
    int          a_req_cnt = 0;

    always #5 clk = ~clk;

    run_ctrl #(.AW(8), .LOAD_BASE(0), .LOAD_LEN(4), .UNLOAD_BASE(64), .UNLOAD_LEN(4),
               .TMO_W(16), .TMO_MAX(16'd20)) dut_a (
        .clk(clk), .reset(reset), .start(a_start), .busy(a_busy), .finished(a_finished),
        .timed_out(a_timed_out), .in_valid(a_in_valid), .in_data(a_in_data),
        .in_ready(a_in_ready), .out_valid(a_out_valid), .out_data(a_out_data),
        .out_ready(a_out_ready), .core_reset(a_core_reset), .core_req(a_core_req),
        .core_done(a_core_done), .mem_sel(a_mem_sel), .mem_wr_en(a_mem_wr_en),
        .mem_addr(a_mem_addr), .mem_wr_data(a_mem_wr_data), .mem_rd_data(a_mem_rd_data),
        .cycle_cnt(a_cycle_cnt)
    );

    run_ctrl #(.AW(8), .LOAD_BASE(0), .LOAD_LEN(0), .UNLOAD_BASE(64), .UNLOAD_LEN(0),
               .TMO_W(16), .TMO_MAX(16'hFFFF)) dut_b (
        .clk(clk), .reset(reset), .start(b_start), .busy(b_busy), .finished(b_finished),
        .timed_out(b_timed_out), .in_valid(1'b0), .in_data(8'h00),
        .in_ready(b_in_ready), .out_valid(b_out_valid), .out_data(b_out_data),
        .out_ready(1'b0), .core_reset(b_core_reset), .core_req(b_core_req),
        .core_done(b_core_done), .mem_sel(b_mem_sel), .mem_wr_en(b_mem_wr_en),
        .mem_addr(b_mem_addr), .mem_wr_data(b_mem_wr_data), .mem_rd_data(8'h00),
        .cycle_cnt(b_cycle_cnt)
    );

    // Data memory with combinational read; the core copies mem[0..3] to mem[64..67] on req.
    assign a_mem_rd_data = mem[a_mem_addr];
    always @(posedge clk) begin
        if (a_mem_sel && a_mem_wr_en) mem[a_mem_addr] <= a_mem_wr_data;
        if (a_core_req) begin
            for (int i = 0; i < 4; i++) mem[64 + i] <= mem[i];
            a_req_cnt <= a_req_cnt + 1;
        end
    end

    // Core model: done rises at the negedge of its a_done_at-th run cycle.
    always @(negedge clk) begin
        if (a_core_reset) begin
            a_run_k     <= 0;
            a_core_done <= 1'b0;
        end else begin
            a_run_k     <= a_run_k + 1;
            a_core_done <= ((a_run_k + 1) >= a_done_at);
        end
    end

    function automatic logic [31:0] exp_cc(input int n);
`ifdef RUN_CTRL_CYCLE_CNT_EN
        return 32'(n);
`else
        return 32'(n * 0);
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic a_go();
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
    endtask

    // Load four bytes (b[7:0] first), with `gap` idle cycles before each byte.
    task automatic load4(input logic [31:0] b, input int gap);
        for (int k = 0; k < 4; k++) begin
            for (int g = 0; g < gap; g++) begin
                a_in_valid = 1'b0;
                #1 chk("load_stall_we", 32'(a_mem_wr_en), 32'd0);
                tick();
            end
            a_in_valid = 1'b1;
            a_in_data  = b[8*k +: 8];
            #1;
            chk("load_we", 32'(a_mem_wr_en), 32'd1);
            chk("load_addr", 32'(a_mem_addr), 32'(k));
            chk("load_data", 32'(a_mem_wr_data), 32'(b[8*k +: 8]));
            tick();
            a_in_valid = 1'b0;
        end
    endtask

    // Accept four bytes, stalling `stall_n` cycles before byte `stall_at`.
    task automatic unload4(input logic [31:0] b, input int stall_at, input int stall_n);
        for (int k = 0; k < 4; k++) begin
            if (k == stall_at) begin
                a_out_ready = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    #1 chk("unload_hold", 32'(a_out_data), 32'(b[8*k +: 8]));
                    tick();
                end
            end
            a_out_ready = 1'b1;
            #1;
            chk("unload_valid", 32'(a_out_valid), 32'd1);
            chk("unload_addr", 32'(a_mem_addr), 32'(64 + k));
            chk("unload_data", 32'(a_out_data), 32'(b[8*k +: 8]));
            tick();
            a_out_ready = 1'b0;
        end
    endtask

    // From CORE_RST, step until UNLOAD or IDLE, counting hold and run cycles.
    task automatic wait_run(output int crst, output int runc, output bit ok);
        crst = 0;
        runc = 0;
        ok   = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (a_out_valid || !a_busy) begin
                ok = 1'b1;
                break;
            end
            if (!a_core_reset) runc++;
            else if (a_busy && !a_in_ready) crst++;
            tick();
        end
    endtask

    int crst, runc, req0;
    bit ok;

    initial begin
        tick();
        tick();
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_flags", {30'd0, a_finished, a_timed_out}, 32'd0);
        chk("rst_core", {29'd0, a_core_reset, a_mem_sel, a_core_req}, 32'd6);
        chk("rst_io", {29'd0, a_in_ready, a_out_valid, a_mem_wr_en}, 32'd0);
        chk("rst_addr", 32'(a_mem_addr), 32'd0);
        chk("rst_cc", 32'(a_cycle_cnt), 32'd0);
        reset = 1'b0;
        tick();

        // Run 1: plain load/unload, done after 10 run cycles.
        a_done_at = 10;
        a_go();
        chk("r1_in_ready", 32'(a_in_ready), 32'd1);
        load4(32'h44332211, 0);
        wait_run(crst, runc, ok);
        chk("r1_bound", 32'(ok), 32'd1);
        chk("r1_crst", 32'(crst), 32'd2);
        chk("r1_runc", 32'(runc), 32'd10);
        unload4(32'h44332211, 9, 0);
        chk("r1_idle", 32'(a_busy), 32'd0);
        chk("r1_flags", {30'd0, a_finished, a_timed_out}, 32'd2);
        chk("r1_cc", 32'(a_cycle_cnt), exp_cc(10));
        chk("r1_core_reset", 32'(a_core_reset), 32'd1);

        // Run 2: in_valid every other cycle, 3-cycle unload stall.
        a_done_at = 5;
        a_go();
        chk("r2_fin_clr", 32'(a_finished), 32'd0);
        load4(32'hC33C5AA5, 1);
        wait_run(crst, runc, ok);
        chk("r2_bound", 32'(ok), 32'd1);
        chk("r2_runc", 32'(runc), 32'd5);
        unload4(32'hC33C5AA5, 2, 3);
        chk("r2_flags", {29'd0, a_busy, a_finished, a_timed_out}, 32'd2);
        chk("r2_cc", 32'(a_cycle_cnt), exp_cc(5));

        // Run 3: core never finishes -> timeout after 20 run cycles.
        a_done_at = 100000;
        a_go();
        load4(32'h0D0C0B0A, 0);
        wait_run(crst, runc, ok);
        chk("r3_bound", 32'(ok), 32'd1);
        chk("r3_runc", 32'(runc), 32'd20);
        chk("r3_no_unload", 32'(a_out_valid), 32'd0);
        chk("r3_flags", {29'd0, a_busy, a_finished, a_timed_out}, 32'd3);
        chk("r3_core_reset", 32'(a_core_reset), 32'd1);
        chk("r3_cc", 32'(a_cycle_cnt), exp_cc(20));

        // Run 4: done already high in the request cycle.
        a_done_at = 1;
        req0 = a_req_cnt;
        a_go();
        chk("r4_tmo_clr", 32'(a_timed_out), 32'd0);
        load4(32'h04030201, 0);
        chk("r4_crst1", {30'd0, a_core_reset, a_core_req}, 32'd2);
        tick();
        chk("r4_crst2", {30'd0, a_core_reset, a_core_req}, 32'd2);
        tick();
        chk("r4_req", {29'd0, a_core_reset, a_core_req, a_out_valid}, 32'd2);
        tick();
        chk("r4_done_ignored", {29'd0, a_core_reset, a_core_req, a_out_valid}, 32'd0);
        tick();
        chk("r4_unload", 32'(a_out_valid), 32'd1);
        chk("r4_req_once", 32'(a_req_cnt - req0), 32'd1);
        unload4(32'h04030201, 9, 0);
        chk("r4_cc", 32'(a_cycle_cnt), exp_cc(2));

        // Run 5: reset after two writes, then restart from LOAD_BASE.
        a_done_at = 10;
        a_go();
        a_in_valid = 1'b1;
        a_in_data  = 8'h77;
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("r5_rst_busy", {28'd0, a_busy, a_in_ready, a_mem_wr_en, a_out_valid}, 32'd0);
        chk("r5_rst_core", {30'd0, a_core_reset, a_mem_sel}, 32'd3);
        chk("r5_rst_addr", 32'(a_mem_addr), 32'd0);
        chk("r5_rst_flags", {30'd0, a_finished, a_timed_out}, 32'd0);
        a_in_valid = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        a_go();
        a_in_valid = 1'b1;
        #1 chk("r5_reload_addr", 32'(a_mem_addr), 32'd0);
        a_in_valid = 1'b0;

        // Instance B: zero lengths; start held during RUN is ignored.
        b_core_done = 1'b1;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        chk("b_crst", {29'd0, b_busy, b_in_ready, b_core_reset}, 32'd5);
        tick();
        tick();
        chk("b_req", {29'd0, b_core_reset, b_core_req, b_out_valid}, 32'd2);
        b_start = 1'b1;
        tick();
        chk("b_run2", {29'd0, b_busy, b_core_reset, b_core_req}, 32'd4);
        tick();
        b_start = 1'b0;
        chk("b_idle", {29'd0, b_busy, b_finished, b_timed_out}, 32'd2);
        chk("b_cc", 32'(b_cycle_cnt), exp_cc(2));
        tick();
        chk("b_no_restart", 32'(b_busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/run_ctrl.md
Name: run_ctrl

Overview:
- Host-side sequencer directly upstream of the processor top level.
- Preloads operand bytes into data memory through a side port while the core is held in reset, then issues `req` to the core and waits for `done` under a timeout.
- After the run, streams result bytes back out of data memory.
- Turns the core into a start/finished accelerator for the bench or host.

Parameters:
- AW, 8, data memory address width.
- LOAD_BASE, 0, first data-memory address written during load.
- LOAD_LEN, 32, number of bytes loaded (0 legal).
- UNLOAD_BASE, 64, first data-memory address read during unload.
- UNLOAD_LEN, 32, number of bytes unloaded (0 legal).
- TMO_W, 16, width of the run-cycle counter.
- TMO_MAX, 16'hFFFF, run cycles allowed before timeout.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  host start; honoured only in IDLE.
- busy  out  1  high in every state except IDLE.
- finished  out  1  sticky; set on entry to IDLE after a run; cleared by next accepted start.
- timed_out  out  1  sticky; set when a run timed out; cleared by next accepted start.
- in_valid  in  1  load byte valid.
- in_data  in  8  load byte.
- in_ready  out  1  high only in LOAD.
- out_valid  out  1  high only in UNLOAD.
- out_data  out  8  unload byte; equals mem_rd_data.
- out_ready  in  1  host accepts unload byte.
- core_reset  out  1  reset to core top level.
- core_req  out  1  core request pulse.
- core_done  in  1  core done level.
- mem_sel  out  1  1 = this block owns data-memory port; 0 = core owns it.
- mem_wr_en  out  1  data-memory write enable.
- mem_addr  out  AW  data-memory address.
- mem_wr_data  out  8  data-memory write data.
- mem_rd_data  in  8  data-memory read data (combinational read, same cycle as mem_addr).
- cycle_cnt  out  TMO_W  run-cycle count of last run.

Behaviour:
- Reset state (asynchronous):
  - State = IDLE.
  - core_reset = 1, mem_sel = 1.
  - core_req, busy, finished, timed_out, in_ready, out_valid, mem_wr_en = 0.
  - mem_addr, mem_wr_data = 0.
  - cycle_cnt and internal index counter = 0.
  - Reset asserted mid-operation aborts immediately; no partial status survives.
- core_reset = 1 in all states except RUN.
- mem_sel = 0 only in RUN.
- IDLE:
  - start = 1 clears finished, timed_out, cycle_cnt and the index counter.
  - Next state is LOAD, or CORE_RST if LOAD_LEN = 0.
- LOAD:
  - in_ready = 1.
  - Each cycle with in_valid & in_ready: mem_wr_en = 1, mem_addr = LOAD_BASE + idx (mod 2^AW), mem_wr_data = in_data, idx++.
  - The cycle of the LOAD_LEN-th write moves to CORE_RST and clears idx.
  - in_valid low stalls indefinitely with no write.
- CORE_RST:
  - Holds core_reset for exactly 2 cycles.
  - Then moves to RUN.
- RUN:
  - core_req = 1 on the first RUN cycle only.
  - cycle_cnt increments every RUN cycle, saturating at TMO_MAX.
  - core_done is ignored in the req cycle and sampled from the following cycle.
  - core_done = 1 moves to UNLOAD, or to IDLE if UNLOAD_LEN = 0.
  - cycle_cnt = TMO_MAX with core_done = 0: set timed_out, go to IDLE, skip unload.
  - core_done and timeout in the same cycle: done wins.
- UNLOAD:
  - out_valid = 1, mem_addr = UNLOAD_BASE + idx (mod 2^AW), out_data = mem_rd_data.
  - out_valid & out_ready advances idx.
  - out_data is stable while out_ready = 0.
  - The UNLOAD_LEN-th handshake goes to IDLE.
- Entry to IDLE from RUN or UNLOAD sets finished = 1.
- start while busy: ignored, no effect.

Optional Feature:
- Macro RUN_CTRL_CYCLE_CNT_EN.
- Defined: cycle_cnt port reflects the run counter as described.
- Undefined: cycle_cnt is driven constant 0 and its register is removed. The timeout then uses an internal counter of the same width that is not exported.
- Timeout behaviour is identical either way.

Decomposition:
- Package run_ctrl_pkg: state enum {IDLE, LOAD, CORE_RST, RUN, UNLOAD}, constant CORE_RST_CYCLES = 2.
- Sub-module up_cnt (parameterised width, clear, enable, saturate-at-max): used for idx and cycle_cnt.

Test Plan:
- Load and unload: LOAD_LEN = 4 bytes {11,22,33,44}; core model copies mem[0..3] to mem[64..67] and raises done after 10 cycles -> unload stream is 11,22,33,44; finished = 1, timed_out = 0, cycle_cnt = 10.
- Backpressure: in_valid toggles every other cycle and out_ready is low for 3 cycles mid-unload -> no duplicated or dropped bytes; out_data held while stalled.
- Timeout: TMO_MAX = 20, core_done never rises -> timed_out = 1 after 20 RUN cycles; no out_valid; finished = 1; core_reset back to 1.
- Core boundary: core_done = 1 already in the req cycle -> ignored that cycle, accepted next cycle; exactly one core_req pulse; core_reset high for exactly 2 cycles before RUN.
- Zero-length and ignored start: LOAD_LEN = 0, UNLOAD_LEN = 0 -> IDLE → CORE_RST → RUN → IDLE. start pulsed during RUN -> no restart.
- Reset mid-run: reset during LOAD after 2 writes -> all outputs at reset values immediately; a new start reloads from LOAD_BASE.
